lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 166 ++++++++++++++++
 tb/tb_lsu.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: accepts one pipeline request, runs one memory-port access, then holds the response.
// Optional misalignment/size fault detection is built in when LSU_FAULT_EN is defined.
module lsu #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [WORD_SIZE-1:0] resp_rdata,
    output logic                 resp_fault,
    output logic                 mem_en_write,
    output logic                 mem_en_read,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_din,
    output logic [1:0]           mem_size,
    output logic                 mem_unsigned,
    input  logic [WORD_SIZE-1:0] mem_dout,
    output logic [1:0]           dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // a response transfers on a rising edge where resp_valid && resp_ready.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                 state, state_next;
    logic                   r_write;
    logic [ADDR_SIZE-1:0]   r_addr;
    logic [WORD_SIZE-1:0]   r_wdata;
    logic [1:0]             r_size;
    logic                   r_unsigned;
    logic                   r_fault;
    logic [WORD_SIZE-1:0]   r_rdata;
    logic                   r_captured;

    logic                   accept;
    logic                   req_fault;
    logic [1:0]             eff_size;
    logic [ADDR_SIZE-1:0]   eff_addr;
    logic [WORD_SIZE-1:0]   lane_data;

    assign accept    = req_valid && (state == IDLE);
    assign dbg_state = state;

`ifdef LSU_FAULT_EN
    always_comb begin
        req_fault = (req_size == 2'b11)
                 || (req_size == 2'b01 && req_addr[0])
                 || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    end

    assign eff_size = r_size;
    assign eff_addr = r_addr;
`else
    assign req_fault = 1'b0;

    // Without fault detection, size 11 acts as a word and the address is aligned down.
    always_comb begin
        eff_size = (r_size == 2'b11) ? 2'b10 : r_size;
        eff_addr = r_addr;
        if (eff_size == 2'b01) begin
            eff_addr[0] = 1'b0;
        end else if (eff_size == 2'b10) begin
            eff_addr[1:0] = 2'b00;
        end
    end
`endif

    always_comb begin
        lane_data = r_wdata;
        if (eff_size == 2'b00) begin
            lane_data = {{(WORD_SIZE-8){1'b0}}, r_wdata[7:0]} << {eff_addr[1:0], 3'b000};
        end else if (eff_size == 2'b01) begin
            lane_data = {{(WORD_SIZE-16){1'b0}}, r_wdata[15:0]} << {eff_addr[1], 4'b0000};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_fault    <= 1'b0;
            r_rdata    <= '0;
            r_captured <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                r_write    <= req_write;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_fault    <= req_fault;
                r_captured <= 1'b0;
            end
            // mem_dout is only guaranteed in the first RESP cycle; keep it for backpressure.
            if (state == RESP && !r_captured) begin
                r_rdata    <= mem_dout;
                r_captured <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_rdata   = '0;
        resp_fault   = 1'b0;
        mem_en_write = 1'b0;
        mem_en_read  = 1'b0;
        mem_addr     = '0;
        mem_din      = '0;
        mem_size     = 2'b00;
        mem_unsigned = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = req_fault ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_addr     = eff_addr;
                mem_din      = lane_data;
                mem_size     = eff_size;
                mem_unsigned = r_unsigned;
                mem_en_write = r_write;
                mem_en_read  = !r_write;
                state_next   = RESP;
            end
            RESP: begin
                mem_addr     = eff_addr;
                mem_din      = lane_data;
                mem_size     = eff_size;
                mem_unsigned = r_unsigned;
                resp_valid   = 1'b1;
                resp_fault   = r_fault;
                if (!r_write && !r_fault) begin
                    resp_rdata = r_captured ? r_rdata : mem_dout;
                end
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Directed and randomized checks of lsu against a byte-array reference model and a word-array memory stub.
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_en_write;
    logic        mem_en_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] mem_dout;
    logic [1:0]  dbg_state;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] stub_mem [16];
    logic [7:0]  ref_mem  [64];

    lsu #(.WORD_SIZE(32), .ADDR_SIZE(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault),
        .mem_en_write(mem_en_write), .mem_en_read(mem_en_read), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .mem_dout(mem_dout), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Memory stub: lane writes into words; loads return extended data one cycle after the
    // read enable, garbage otherwise so the LSU must hold its own copy.
    always @(posedge clk) begin
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        w = stub_mem[mem_addr[5:2]];
        if (mem_en_write) begin
            for (int l = 0; l < 4; l++) begin
                if ((mem_size == 2'b00 && l == int'(mem_addr[1:0])) ||
                    (mem_size == 2'b01 && (l >> 1) == int'(mem_addr[1])) ||
                    (mem_size[1])) begin
                    w[l*8 +: 8] = mem_din[l*8 +: 8];
                end
            end
            stub_mem[mem_addr[5:2]] <= w;
        end
        if (mem_en_read) begin
            b = w[mem_addr[1:0]*8 +: 8];
            h = w[mem_addr[1]*16 +: 16];
            if (mem_size == 2'b00)      mem_dout <= mem_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
            else if (mem_size == 2'b01) mem_dout <= mem_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
            else                        mem_dout <= w;
        end else begin
            mem_dout <= $urandom;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] ea, input logic [1:0] sz, input logic un);
        int i;
        logic [7:0]  b;
        logic [15:0] h;
        i = int'(ea[5:0]);
        b = ref_mem[i];
        if (sz == 2'b00) return un ? {24'd0, b} : {{24{b[7]}}, b};
        h = {ref_mem[i+1], ref_mem[i]};
        if (sz == 2'b01) return un ? {16'd0, h} : {{16{h[15]}}, h};
        return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
    endfunction

    // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input logic un, input int stall);
        logic        flt;
        logic [1:0]  esz;
        logic [31:0] ea, din, rd;
        int          nbytes;
`ifdef LSU_FAULT_EN
        flt = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        esz = sz;
        ea  = a;
`else
        flt = 1'b0;
        esz = (sz == 2'b11) ? 2'b10 : sz;
        ea  = (esz == 2'b00) ? a : (esz == 2'b01) ? (a & ~32'd1) : (a & ~32'd3);
`endif
        nbytes = (esz == 2'b00) ? 1 : (esz == 2'b01) ? 2 : 4;
        din = 32'd0;
        for (int k = 0; k < nbytes; k++) begin
            din = din | ({24'd0, wd[k*8 +: 8]} << (8 * ((int'(ea[1:0]) + k) % 4)));
        end
        rd = (wr || flt) ? 32'd0 : ref_load(ea, esz, un);

        chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        req_size = sz; req_unsigned = un; resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        if (!flt) begin
            chk("access_en_write", {31'd0, mem_en_write}, {31'd0, wr});
            chk("access_en_read", {31'd0, mem_en_read}, {31'd0, !wr});
            chk("access_mem_addr", mem_addr, ea);
            chk("access_mem_size", {30'd0, mem_size}, {30'd0, esz});
            chk("access_mem_unsigned", {31'd0, mem_unsigned}, {31'd0, un});
            if (wr) chk("access_mem_din", mem_din, din);
            chk("access_resp_valid", {31'd0, resp_valid}, 32'd0);
            chk("access_req_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        for (int s = 0; s <= stall; s++) begin
            chk("resp_enables", {30'd0, mem_en_write, mem_en_read}, 32'd0);
            chk("resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("resp_fault", {31'd0, resp_fault}, {31'd0, flt});
            chk("resp_rdata", resp_rdata, rd);
            chk("resp_req_ready", {31'd0, req_ready}, 32'd0);
            if (!flt) chk("resp_mem_addr", mem_addr, ea);
            if (s < stall) @(negedge clk);
        end
        // A request presented as the response completes must not be taken.
        resp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'd0; req_size = 2'b00;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b0;
        chk("after_req_ready", {31'd0, req_ready}, 32'd1);
        chk("after_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("after_enables", {30'd0, mem_en_write, mem_en_read}, 32'd0);
        chk("after_mem_addr", mem_addr, 32'd0);
        if (wr && !flt) begin
            for (int k = 0; k < nbytes; k++) ref_mem[int'(ea[5:0]) + k] = wd[k*8 +: 8];
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) stub_mem[i] = 32'd0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'd0;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_size = 2'b00; req_unsigned = 1'b0; resp_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_enables", {30'd0, mem_en_write, mem_en_read}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_din", mem_din, 32'd0);
        chk("rst_mem_size_unsigned", {29'd0, mem_size, mem_unsigned}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(1'b1, 32'h10, 32'hCAFEBABE, 2'b10, 1'b0, 0);
        do_req(1'b1, 32'h13, 32'h000000A5, 2'b00, 1'b0, 0);
        do_req(1'b1, 32'h11, 32'h00000080, 2'b00, 1'b0, 0);
        do_req(1'b0, 32'h11, 32'h0, 2'b00, 1'b0, 0);
        do_req(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 3);
        do_req(1'b0, 32'h6, 32'h0, 2'b10, 1'b0, 0);
        do_req(1'b0, 32'h13, 32'h0, 2'b01, 1'b1, 1);
        do_req(1'b1, 32'h22, 32'h1234ABCD, 2'b01, 1'b0, 0);
        do_req(1'b0, 32'h22, 32'h0, 2'b01, 1'b0, 0);
        do_req(1'b1, 32'h2F, 32'h0, 2'b11, 1'b0, 0);

        // Reset asserted while the read enable is high abandons the access at once.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_size = 2'b10; req_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid_en_read_before", {31'd0, mem_en_read}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_enables_drop", {30'd0, mem_en_write, mem_en_read}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rstmid_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rstmid_mem_addr", mem_addr, 32'd0);

        for (int n = 0; n < 80; n++) begin
            do_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), $urandom,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
